// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ==== ps2_key_event_ctrl: PS/2 scan-code decoder + event FIFO on the PicoBlaze I/O bus (rev 1.0)
// ==== Optional macro KEY_BREAK_EVENTS_EN: when defined, F0 (break) events are queued as well.
module ps2_key_event_ctrl #(
  parameter int         DEPTH_LOG2  = 2,
  parameter logic [7:0] STATUS_PORT = 8'h01,
  parameter logic [7:0] DATA_PORT   = 8'h02,
  parameter int         TIMEOUT_CYC = 1_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       overflow
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  B_E0     = 8'hE0;
  localparam logic [7:0]  B_F0     = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] tmo_q, tmo_d;
  logic        ev_valid, ev_ext, ev_brk, ev_push;

  logic [9:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;
  logic                  irq_q, irq_d, ovf_q, ovf_d;

  logic       nonempty, full, pop, accept, status_rd;
  logic [9:0] head;
  logic       head_ext, head_brk;

  // ---------------- decoder FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    ev_valid = 1'b0;
    ev_ext   = 1'b0;
    ev_brk   = 1'b0;
    if (rx_done_tick) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == B_E0)      state_d = ST_GOT_E0;
          else if (rx_byte == B_F0) state_d = ST_GOT_F0;
          else                      ev_valid = 1'b1;
        end
        ST_GOT_E0: begin
          if (rx_byte == B_F0)      state_d = ST_GOT_E0F0;
          else if (rx_byte != B_E0) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          state_d = ST_IDLE;
          if (rx_byte != B_E0 && rx_byte != B_F0) begin
            ev_valid = 1'b1;
            ev_brk   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (rx_byte != B_E0 && rx_byte != B_F0) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            ev_brk   = 1'b1;
          end
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      // Stale prefix: abandon it so a lost byte cannot corrupt the next key.
      state_d = ST_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end
  end

`ifdef KEY_BREAK_EVENTS_EN
  assign ev_push = ev_valid;
`else
  assign ev_push = ev_valid & ~ev_brk;
`endif

  // ---------------- event FIFO ----------------
  assign nonempty  = (count_q != 3'd0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = read_strobe && (port_id == DATA_PORT) && nonempty;
  assign status_rd = read_strobe && (port_id == STATUS_PORT);
  // When full, a simultaneous pop frees the head slot this very edge.
  assign accept    = ev_push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept && !pop)      count_d = count_q + 3'd1;
    else if (pop && !accept) count_d = count_q - 3'd1;
    if (accept)             irq_d = 1'b1;
    else if (interrupt_ack) irq_d = 1'b0;
    if (ev_push && !accept) ovf_d = 1'b1;
    else if (status_rd)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {ev_ext, ev_brk, rx_byte};
  end

  // ---------------- read port ----------------
  assign head     = mem_q[rd_ptr_q];
  assign head_ext = nonempty & head[9];
`ifdef KEY_BREAK_EVENTS_EN
  assign head_brk = nonempty & head[8];
`else
  assign head_brk = 1'b0;
`endif

  always_comb begin
    in_port = 8'h00;
    if (port_id == STATUS_PORT)
      in_port = {nonempty, full, ovf_q, head_ext, head_brk, count_q};
    else if (port_id == DATA_PORT && nonempty)
      in_port = head[7:0];
  end

  assign interrupt = irq_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ==== tb_ps2_key_event_ctrl: directed + randomized bench against a queue-based event model (rev 1.0)
module tb_ps2_key_event_ctrl;
  localparam int         DL    = 2;
  localparam int         DEPTH = 1 << DL;
  localparam int         TMO   = 100;
  localparam logic [7:0] SP    = 8'h01;
  localparam logic [7:0] DP    = 8'h02;
`ifdef KEY_BREAK_EVENTS_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, rx_done_tick = 1'b0;
  logic [7:0] rx_byte = 8'h00, port_id = 8'h00;
  logic       read_strobe = 1'b0, interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt, overflow;

  ps2_key_event_ctrl #(.DEPTH_LOG2(DL), .STATUS_PORT(SP), .DATA_PORT(DP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_byte(rx_byte),
    .port_id(port_id), .read_strobe(read_strobe), .interrupt_ack(interrupt_ack),
    .in_port(in_port), .interrupt(interrupt), .overflow(overflow));

  always #5 clk = ~clk;

  // Model: prefix flags, a queue of {ext,brk,code}, and the two sticky outputs.
  logic [9:0] mq[$];
  bit m_e, m_f, m_irq, m_ovf;
  int m_tcnt;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_in(input logic [7:0] pid);
    logic ne, fl, hx, hb;
    logic [7:0] code;
    ne = (mq.size() != 0);
    fl = (mq.size() == DEPTH);
    hx = ne ? mq[0][9] : 1'b0;
    hb = ne ? mq[0][8] : 1'b0;
    code = ne ? mq[0][7:0] : 8'h00;
    if (pid == SP) return {ne, fl, m_ovf, hx, hb, 3'(mq.size())};
    if (pid == DP) return code;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    bit push, pop, acc;
    logic [9:0] ev;
    push = 1'b0;
    ev = '0;
    if (reset) begin
      mq.delete();
      m_e = 0; m_f = 0; m_irq = 0; m_ovf = 0; m_tcnt = 0;
    end else begin
      if (rx_done_tick) begin
        m_tcnt = 0;
        if (rx_byte == 8'hE0) begin
          if (m_f) begin m_e = 0; m_f = 0; end else m_e = 1;
        end else if (rx_byte == 8'hF0) begin
          if (m_f) begin m_e = 0; m_f = 0; end else m_f = 1;
        end else begin
          ev = {m_e, m_f, rx_byte};
          push = BRK_EN || !m_f;
          m_e = 0; m_f = 0;
        end
      end else if (m_e || m_f) begin
        if (m_tcnt == TMO - 1) begin m_e = 0; m_f = 0; m_tcnt = 0; end
        else m_tcnt++;
      end else m_tcnt = 0;
      pop = read_strobe && port_id == DP && mq.size() != 0;
      if (pop) void'(mq.pop_front());
      acc = push && mq.size() < DEPTH;
      if (acc) mq.push_back(ev);
      if (push && !acc) m_ovf = 1;
      else if (read_strobe && port_id == SP) m_ovf = 0;
      if (acc) m_irq = 1;
      else if (interrupt_ack) m_irq = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_port", in_port, exp_in(port_id));
      check("interrupt", {7'd0, interrupt}, {7'd0, m_irq});
      check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] v);
    port_id = p; read_strobe = 1'b1;
    @(negedge clk); v = in_port;
    tick();
    read_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic peek(input logic [7:0] p, output logic [7:0] v);
    port_id = p;
    @(negedge clk); v = in_port;
    tick();
    port_id = 8'h00;
  endtask

  logic [7:0] v;
  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    peek(SP, v); check("reset_status", v, 8'h00);
    peek(DP, v); check("reset_data", v, 8'h00);
    @(negedge clk); check("reset_irq", {7'd0, interrupt}, 8'h00);
    reset = 1'b0; tick();

    // Make, then break of the same key
    send(8'h1C);
    peek(SP, v); check("one_make_status", v, 8'h81);
    @(negedge clk); check("irq_set", {7'd0, interrupt}, 8'h01);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    @(negedge clk); check("irq_ack", {7'd0, interrupt}, 8'h00);
    repeat (50) tick(); send(8'hF0); repeat (50) tick(); send(8'h1C);
    rd(DP, v); check("make_code", v, 8'h1C);
    peek(SP, v); check("break_status", v, BRK_EN ? 8'h89 : 8'h00);
    rd(DP, v); check("break_code", v, BRK_EN ? 8'h1C : 8'h00);

    // Extended make and extended break
    send(8'hE0); send(8'h75);
    peek(SP, v); check("ext_make_status", v, 8'h91);
    rd(DP, v); check("ext_make_code", v, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    peek(SP, v); check("ext_break_status", v, BRK_EN ? 8'h99 : 8'h00);
    rd(DP, v); check("ext_break_code", v, BRK_EN ? 8'h75 : 8'h00);

    // Overflow, clear-on-read, then full with a coincident pop and push
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    peek(SP, v); check("full_ovf_status", v, 8'hE4);
    rd(SP, v); check("status_preclear", v, 8'hE4);
    peek(SP, v); check("status_cleared", v, 8'hC4);
    rd(DP, v); check("pop_15", v, 8'h15);
    send(8'h2C);
    rx_byte = 8'h35; rx_done_tick = 1'b1; port_id = DP; read_strobe = 1'b1;
    @(negedge clk); v = in_port; check("pop_1D_with_push", v, 8'h1D);
    tick();
    rx_done_tick = 1'b0; read_strobe = 1'b0; port_id = 8'h00;
    peek(SP, v); check("full_no_ovf", v, 8'hC4);
    rd(DP, v); check("pop_24", v, 8'h24);
    rd(DP, v); check("pop_2D", v, 8'h2D);
    rd(DP, v); check("pop_2C", v, 8'h2C);
    rd(DP, v); check("pop_35", v, 8'h35);

    // Timeout inside a break prefix
    send(8'hF0); repeat (TMO) tick(); send(8'h1C);
    peek(SP, v); check("timeout_status", v, 8'h81);
    rd(DP, v); check("timeout_code", v, 8'h1C);

    // Reset mid-sequence
    send(8'h11); send(8'h12); send(8'h13); send(8'hE0);
    reset = 1'b1; tick(); reset = 1'b0;
    peek(SP, v); check("post_reset_status", v, 8'h00);
    check("post_reset_irq", {7'd0, interrupt}, 8'h00);
    send(8'h75);
    peek(SP, v); check("post_reset_event", v, 8'h81);
    rd(DP, v); check("post_reset_code", v, 8'h75);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom % 250 == 0) begin
        rx_done_tick = 0; read_strobe = 0; interrupt_ack = 0;
        repeat (TMO + $urandom_range(0, 3) - 2) tick();
      end
      r = $urandom % 10;
      rx_done_tick = ($urandom % 3 == 0);
      rx_byte = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(1, 8'hDF));
      r = $urandom % 3;
      port_id = (r == 0) ? SP : (r == 1) ? DP : 8'($urandom);
      read_strobe = ($urandom % 3 == 0);
      interrupt_ack = ($urandom % 5 == 0);
      reset = ($urandom % 600 == 0);
      tick();
    end
    rx_done_tick = 0; read_strobe = 0; interrupt_ack = 0; reset = 0;
    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
